// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: multi-cycle WIDTH-bit ALU built around a 4-bit slice.
// Operands are latched on accept, processed one nibble per clock (LS nibble
// first) with carry chained between nibbles, and the assembled result plus
// flags are presented through a valid/ready output handshake.
module alu_nibble_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_n,
  output logic             busy
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_NOR   = 3'b101,
    OP_NOTA  = 3'b110,
    OP_PASSB = 3'b111
  } op_t;

  state_t           state;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IDXW-1:0]  idx;
  logic             carry;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       bp_nib;
  logic [4:0]       sum;
  logic [3:0]       r_nib;
  logic             is_arith;
  logic             c_next;
  logic             bp_msb;
  logic             v_next;
  logic [WIDTH-1:0] res_next;

  // Handshake/status outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state == S_IDLE) && !rst;
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // 4-bit slice: select nibble idx, compute it, and merge into the result.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end

    is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    bp_nib   = (op_q == OP_SUB) ? ~b_nib : b_nib;
    sum      = {1'b0, a_nib} + {1'b0, bp_nib} + {4'b0000, carry};

    case (op_q)
      OP_ADD,
      OP_SUB:   r_nib = sum[3:0];
      OP_AND:   r_nib = a_nib & b_nib;
      OP_OR:    r_nib = a_nib | b_nib;
      OP_XOR:   r_nib = a_nib ^ b_nib;
      OP_NOR:   r_nib = ~(a_nib | b_nib);
      OP_NOTA:  r_nib = ~a_nib;
      default:  r_nib = b_nib;
    endcase

    c_next = is_arith ? sum[4] : 1'b0;

    res_next = result;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        res_next[4*i +: 4] = r_nib;
      end
    end

    bp_msb = (op_q == OP_SUB) ? ~b_q[WIDTH-1] : b_q[WIDTH-1];
    v_next = is_arith && (a_q[WIDTH-1] == bp_msb) &&
             (res_next[WIDTH-1] != a_q[WIDTH-1]);
  end

  // Control FSM plus operand, nibble-index, carry, result and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            op_q   <= op_t'(op);
            idx    <= '0;
            carry  <= (op == OP_SUB);
            result <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          result <= res_next;
          carry  <= c_next;
          if (idx == LAST_IDX) begin
            flag_c <= c_next;
            flag_z <= (res_next == '0);
            flag_v <= v_next;
            flag_n <= res_next[WIDTH-1];
            state  <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
